id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core, with load-use hazard detection. It sits directly downstream of the decode-stage control unit. It captures that unit's wb/m/ex control bundles together with the decode-stage operands, and presents them to the execute stage one cycle later. It also detects load-use hazards, inserts bubbles for them, and supports hold (freeze) and flush (squash) from elsewhere in the pipeline.

## Interface
- DATA_W, 32, width of register-file data, immediate and PC+4
- REG_W, 5, width of register specifiers

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_wb  in  2  control bundle from decode; bit1 = RegWrite
- id_m  in  5  bit0 = MemWrite, bit1 = MemRead, bit2 = Branch, bits4:3 = halfword load type
- id_ex  in  5  bit4 = RegDst, bit0 = ALUSrc, bits3:1 = ALU op class
- id_rs, id_rt, id_rd  in  REG_W each  decoded register specifiers
- id_rdata1, id_rdata2  in  DATA_W each  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of the instruction in decode
- id_valid  in  1  decode holds a real instruction
- hold  in  1  freeze this register (downstream busy)
- flush  in  1  squash the decode instruction (taken branch)
- load_use_stall  out  1  combinational; instructs the PC and IF/ID to hold
- ex_wb, ex_m, ex_ex, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  registered copies of the matching id_* inputs
- ex_valid  out  1  execute holds a real instruction
- bubble_count, flush_count  out  16 each  present only with ID_EX_STATS_EN

## Operation
- Reset sets every ex_* output to 0, ex_valid to 0 and both counters to 0. Reset has top priority.
- Hazard term: load_use_stall = ex_valid & ex_m[1] & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - The id_rt comparison is always made, even when the decoded instruction does not read rt. The resulting extra stall is accepted.
- Per-edge update priority, highest first:
  1. **flush**: all control bundles, ex_valid and the ex_rs/rt/rd fields are cleared to 0. Data fields are don't-care, and are cleared to 0.
  2. **hold**: all registers keep their values. flush has priority over hold.
  3. **load_use_stall**: a bubble is inserted. ex_wb, ex_m, ex_ex and ex_valid go to 0, and all other fields are cleared to 0. The IF/ID instruction is re-presented on the next cycle.
  4. **Otherwise**: all id_* inputs are captured, and ex_valid is set to id_valid.
- When id_valid = 0 and none of the above applies, the bundles are still captured, but ex_valid = 0. Downstream logic qualifies RegWrite, MemRead and MemWrite with ex_valid.
- Don't-care (x) bits from the control unit are passed through unchanged. A bubble or a flush always produces all-zero control.

## Timing
- Latency is 1 cycle from id_* to ex_*.
- load_use_stall is purely combinational from ex_* registers and id_* inputs; it is valid in the same cycle.
- A load followed immediately by a dependent instruction gives exactly one bubble.
  - Cycle N: stall = 1. At edge N+1 the bubble is written; because ex_valid = 0, stall falls to 0.
  - At edge N+2 the dependent instruction is captured.
- While hold = 1, load_use_stall stays at its frozen value and the PC and IF/ID also hold. No bubble is inserted until hold is released.
- flush and load_use_stall in the same cycle: flush wins, and no bubble is counted.
- Asynchronous reset asserted mid-stall clears the stall within the same cycle, because ex_valid goes to 0.

## Configuration
- **ID_EX_STATS_EN defined**:
  - bubble_count increments on each edge where a load-use bubble is written.
  - flush_count increments on each edge where flush is applied.
  - Both are 16-bit, saturating at 16'hFFFF, cleared by rst, and frozen under hold unless flush is asserted.
- **Not defined**: both counters and their ports are absent. The remaining behaviour is identical.

## Test plan
- Reset mid-run, then release → all ex_* = 0 and ex_valid = 0. With stats enabled, both counters = 0.
- Present add $3,$1,$2 (id_wb=2'b11, id_ex=5'b10100, rdata1=5, rdata2=7, valid) → next cycle ex_wb=2'b11, ex_ex=5'b10100, ex_rdata1=5, ex_rdata2=7, ex_valid=1.
- lw $4 (id_m=5'b00010, rt=4), then add with rs=4 → one cycle of load_use_stall=1, then a bubble (ex_m=0, ex_valid=0), then the add is captured. bubble_count=1.
- lw into $0 followed by a reader of $0 → load_use_stall remains 0 and no bubble is inserted.
- flush=1 and hold=1 together while decode holds beq (id_m=5'b00100) → ex_m=0, ex_valid=0. flush_count=1.
- hold=1 for 3 cycles with varying id_* inputs → ex_* outputs remain unchanged. On release, the current id_* values are captured.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, hold and flush.
// Optional bubble/flush statistics counters are enabled by defining ID_EX_STATS_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        id_wb,
    input  logic [4:0]        id_m,
    input  logic [4:0]        id_ex,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              id_valid,
    input  logic              hold,
    input  logic              flush,
    output logic              load_use_stall,
    output logic [1:0]        ex_wb,
    output logic [4:0]        ex_m,
    output logic [4:0]        ex_ex,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic              ex_valid
`ifdef ID_EX_STATS_EN
    ,
    output logic [15:0]       bubble_count,
    output logic [15:0]       flush_count
`endif
);

    logic rt_nonzero_s;
    logic reg_match_s;

    // Load-use hazard: a load in execute writes a register that decode reads (rt compared unconditionally)
    always_comb begin
        rt_nonzero_s   = 1'b0;
        reg_match_s    = 1'b0;
        load_use_stall = 1'b0;
        rt_nonzero_s   = (ex_rt != {REG_W{1'b0}});
        reg_match_s    = (ex_rt == id_rs) || (ex_rt == id_rt);
        if (ex_valid && ex_m[1] && rt_nonzero_s && id_valid && reg_match_s) begin
            load_use_stall = 1'b1;
        end else begin
            load_use_stall = 1'b0;
        end
    end

    // Pipeline register: flush > hold > bubble > capture; bubble and flush both write all zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wb     <= 2'b00;
            ex_m      <= 5'b00000;
            ex_ex     <= 5'b00000;
            ex_rs     <= {REG_W{1'b0}};
            ex_rt     <= {REG_W{1'b0}};
            ex_rd     <= {REG_W{1'b0}};
            ex_rdata1 <= {DATA_W{1'b0}};
            ex_rdata2 <= {DATA_W{1'b0}};
            ex_imm    <= {DATA_W{1'b0}};
            ex_pc4    <= {DATA_W{1'b0}};
            ex_valid  <= 1'b0;
        end else if (flush || (!hold && load_use_stall)) begin
            ex_wb     <= 2'b00;
            ex_m      <= 5'b00000;
            ex_ex     <= 5'b00000;
            ex_rs     <= {REG_W{1'b0}};
            ex_rt     <= {REG_W{1'b0}};
            ex_rd     <= {REG_W{1'b0}};
            ex_rdata1 <= {DATA_W{1'b0}};
            ex_rdata2 <= {DATA_W{1'b0}};
            ex_imm    <= {DATA_W{1'b0}};
            ex_pc4    <= {DATA_W{1'b0}};
            ex_valid  <= 1'b0;
        end else if (!hold) begin
            ex_wb     <= id_wb;
            ex_m      <= id_m;
            ex_ex     <= id_ex;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_pc4    <= id_pc4;
            ex_valid  <= id_valid;
        end else begin
            ex_valid  <= ex_valid;
        end
    end

`ifdef ID_EX_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc = 16'hFFFF;
        end else begin
            sat_inc = value + 16'd1;
        end
    endfunction

    // Statistics: flush counts even under hold; bubbles count only when actually written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= 16'd0;
            flush_count  <= 16'd0;
        end else if (flush) begin
            flush_count  <= sat_inc(flush_count);
        end else if (!hold && load_use_stall) begin
            bubble_count <= sat_inc(bubble_count);
        end else begin
            bubble_count <= bubble_count;
        end
    end
`endif

endmodule
